// File: rtl/riscv_mini_sequencer_pkg.sv
// Shared definitions for the RISC-V-mini program sequencer:
// FSM state encoding, the NOP word, opcode/funct3 codes, default depth
// and the compare-driven skip test.
package riscv_mini_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_t;

  // Opcode 11 / funct3 000: read-only, no register write
  localparam logic [15:0] NOP_INSTR = 16'h0003;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_L = 2'b10;
  localparam logic [1:0] OP_O = 2'b11;

  localparam logic [2:0] F3_CMP = 3'b011;

  localparam int DEFAULT_DEPTH = 8;

  // A compare instruction whose result bit 0 is set skips the next slot
  function automatic logic is_skip(input logic [15:0] instr,
                                   input logic [7:0]  result);
    return (instr[1:0] == OP_O) && (instr[15:13] == F3_CMP) && result[0];
  endfunction

endpackage

// File: rtl/riscv_mini_sequencer_if.sv
// Pin-side and core-side signal bundle of the program sequencer.
// master: whoever feeds the program and the core result (pins / core model).
// slave : the sequencer itself.
// Build option RISCV_MINI_SEQ_LOOP_EN adds the 'stop' input.
interface riscv_mini_sequencer_if #(
  parameter int PCW = 3
);
  logic [7:0]     load_data;
  logic           load_valid;
  logic           load_ready;
  logic           clear;
  logic           start;
  logic [15:0]    instr_out;
  logic           instr_valid;
  logic [7:0]     core_result;
  logic [PCW-1:0] pc;
  logic [7:0]     last_result;
  logic           busy;
  logic           done;
`ifdef RISCV_MINI_SEQ_LOOP_EN
  logic           stop;

  modport master (
    output load_data, load_valid, clear, start, core_result, stop,
    input  load_ready, instr_out, instr_valid, pc, last_result, busy, done
  );

  modport slave (
    input  load_data, load_valid, clear, start, core_result, stop,
    output load_ready, instr_out, instr_valid, pc, last_result, busy, done
  );
`else
  modport master (
    output load_data, load_valid, clear, start, core_result,
    input  load_ready, instr_out, instr_valid, pc, last_result, busy, done
  );

  modport slave (
    input  load_data, load_valid, clear, start, core_result,
    output load_ready, instr_out, instr_valid, pc, last_result, busy, done
  );
`endif
endinterface

// File: rtl/riscv_mini_sequencer_prog_buf.sv
// Program buffer: DEPTH x 16-bit slots. The low byte of an instruction is
// staged, the high byte commits {high, low} to the addressed slot.
// Read is asynchronous so the slot at pc reaches the core in the same cycle.
module riscv_mini_prog_buf #(
  parameter int DEPTH = 8,
  parameter int PCW   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_low,
  input  logic           wr_high,
  input  logic [7:0]     wr_data,
  input  logic [PCW-1:0] wr_addr,
  input  logic [PCW-1:0] rd_addr,
  output logic [15:0]    rd_data
);

  logic [15:0] slots [DEPTH];
  logic [7:0]  low_q;

  // Staging register for the low byte of the instruction being assembled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      low_q <= 8'h00;
    end else if (wr_low) begin
      low_q <= wr_data;
    end
  end

  // Slot array is not reset; the length counter decides which slots are live
  always_ff @(posedge clk) begin
    if (wr_high) begin
      slots[wr_addr] <= {wr_data, low_q};
    end
  end

  assign rd_data = slots[rd_addr];

endmodule

// File: rtl/riscv_mini_sequencer.sv
// Program sequencer for the 8-bit RISC-V-mini core.
// Collects a byte-serial program into riscv_mini_prog_buf, then issues it
// one instruction per clock with a compare-driven skip of the next slot.
// Build option RISCV_MINI_SEQ_LOOP_EN: RUN wraps to pc 0 at each pass end
// until 'stop' is seen high at a termination point.
module riscv_mini_sequencer
  import riscv_mini_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PCW   = $clog2(DEPTH)
) (
  input logic                    clk,
  input logic                    rst_n,
  riscv_mini_sequencer_if.slave  bus
);

  localparam logic [PCW:0] FULL_LEN = (PCW+1)'(DEPTH);

  seq_state_t     state, state_next;
  logic [PCW:0]   length;
  logic           phase_high;
  logic [PCW-1:0] pc_q;
  logic [7:0]     last_q;
  logic           done_q;

  logic [15:0]    slot_rd;
  logic           len_zero;
  logic           start_go;
  logic           load_ok;
  logic           byte_acc;
  logic           run_skip;
  logic [PCW:0]   pc_step;
  logic           run_term;
  logic           keep_running;

  riscv_mini_prog_buf #(
    .DEPTH (DEPTH),
    .PCW   (PCW)
  ) u_prog_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_low  (byte_acc && !phase_high),
    .wr_high (byte_acc && phase_high),
    .wr_data (bus.load_data),
    .wr_addr (length[PCW-1:0]),
    .rd_addr (pc_q),
    .rd_data (slot_rd)
  );

  // start is only honoured outside RUN, on an instruction boundary, and
  // loses to clear. While start or clear is acting, load_ready is dropped
  // so a byte offered in that cycle is simply not taken.
  assign len_zero = (length == '0);
  assign start_go = bus.start && !phase_high && (state != ST_RUN) && !bus.clear;
  assign load_ok  = (state != ST_RUN) && (length != FULL_LEN) && !bus.clear && !start_go;
  assign byte_acc = bus.load_valid && load_ok;

  // Next pc is formed one bit wider so the end-of-program test never wraps
  assign run_skip = is_skip(slot_rd, bus.core_result);
  assign pc_step  = run_skip ? ({1'b0, pc_q} + (PCW+1)'(2))
                             : ({1'b0, pc_q} + (PCW+1)'(1));
  assign run_term = (pc_step >= length);

`ifdef RISCV_MINI_SEQ_LOOP_EN
  assign keep_running = !bus.stop;
`else
  assign keep_running = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.clear) begin
          state_next = ST_IDLE;
        end else if (start_go && !len_zero) begin
          state_next = ST_RUN;
        end else if (byte_acc) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.clear) begin
          state_next = ST_IDLE;
        end else if (start_go && !len_zero) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_term && !keep_running) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    bus.instr_out   = NOP_INSTR;
    bus.instr_valid = 1'b0;
    bus.busy        = 1'b0;
    bus.load_ready  = load_ok;
    if (state == ST_RUN) begin
      bus.instr_out   = slot_rd;
      bus.instr_valid = 1'b1;
      bus.busy        = 1'b1;
    end
  end

  // Length, byte phase, pc, captured result and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      length     <= '0;
      phase_high <= 1'b0;
      pc_q       <= '0;
      last_q     <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_RUN) begin
        if (run_term) begin
          last_q <= bus.core_result;
          done_q <= 1'b1;
          pc_q   <= '0;
        end else begin
          pc_q <= pc_step[PCW-1:0];
        end
      end else if (bus.clear) begin
        length     <= '0;
        phase_high <= 1'b0;
      end else if (start_go) begin
        if (len_zero) begin
          done_q <= 1'b1;
        end
      end else if (byte_acc) begin
        phase_high <= !phase_high;
        if (phase_high) begin
          length <= length + (PCW+1)'(1);
        end
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.last_result = last_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_riscv_mini_sequencer.sv
// Self-checking bench for riscv_mini_sequencer.
// A program-level reference model (byte list -> instruction array, pc
// walk with skip) is compared against the DUT on every falling edge;
// directed sequences add hand-computed literal expectations.
// Honours RISCV_MINI_SEQ_LOOP_EN for the looping RUN variant.
module tb_riscv_mini_sequencer;

  localparam int DEPTH = 8;
  localparam int PCW   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stop_drv = 1'b1;

  always #5 clk = ~clk;

  riscv_mini_sequencer_if #(.PCW(PCW)) bus ();

`ifdef RISCV_MINI_SEQ_LOOP_EN
  assign bus.stop = stop_drv;
`endif

  riscv_mini_sequencer #(
    .DEPTH (DEPTH),
    .PCW   (PCW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] m_mem [DEPTH];
  int          m_len = 0;
  int          m_pc = 0;
  bit          m_have_low = 0;
  bit          m_run = 0;
  bit          m_done = 0;
  bit          m_valid = 0;
  logic [7:0]  m_low = 8'h00;
  logic [7:0]  m_last = 8'h00;

  // Observed issue log for directed checks
  logic [15:0] issued [$];
  int          pc_log [$];
  int          done_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; on return the outputs reflect the new state
  task automatic applyStimulus(input logic lv, input logic [7:0] ld,
                               input logic st, input logic cl,
                               input logic [7:0] cr, input logic sp = 1'b1);
    @(posedge clk);
    #1;
    bus.load_valid  = lv;
    bus.load_data   = ld;
    bus.start       = st;
    bus.clear       = cl;
    bus.core_result = cr;
    stop_drv        = sp;
    #1;
  endtask

  task automatic runUntilDone(input logic [7:0] cr, input string name);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, cr);
      if (bus.done) seen = 1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic loadBytes(input logic [7:0] b [$]);
    foreach (b[i]) applyStimulus(1'b1, b[i], 1'b0, 1'b0, 8'h00);
  endtask

  // Compare DUT with model, log activity, then advance the model using
  // the inputs that the coming rising edge will sample
  always @(negedge clk) begin : compare_proc
    logic [15:0] cur;
    int          nxt;
    bit          keep;
    bit          nd;
    if (m_valid) begin
      cur = m_run ? m_mem[m_pc] : 16'h0003;
      checkOutput("busy",        32'(bus.busy),        32'(m_run));
      checkOutput("instr_valid", 32'(bus.instr_valid), 32'(m_run));
      checkOutput("instr_out",   32'(bus.instr_out),   32'(cur));
      checkOutput("pc",          32'(bus.pc),          32'(m_pc));
      checkOutput("last_result", 32'(bus.last_result), 32'(m_last));
      checkOutput("done",        32'(bus.done),        32'(m_done));
      checkOutput("load_ready",  32'(bus.load_ready),
                  32'(!m_run && m_len < DEPTH && !bus.clear && !(bus.start && !m_have_low)));
    end
    if (bus.instr_valid === 1'b1) begin
      issued.push_back(bus.instr_out);
      pc_log.push_back(int'(bus.pc));
    end
    if (bus.done === 1'b1) done_seen++;

    if (!rst_n) begin
      m_len = 0; m_pc = 0; m_have_low = 0; m_run = 0; m_done = 0; m_last = 8'h00;
      m_valid = 1;
    end else if (m_valid) begin
      nd = 0;
      if (m_run) begin
        cur = m_mem[m_pc];
        nxt = m_pc + ((cur[1:0] == 2'b11 && cur[15:13] == 3'b011 && bus.core_result[0]) ? 2 : 1);
`ifdef RISCV_MINI_SEQ_LOOP_EN
        keep = !bus.stop;
`else
        keep = 0;
`endif
        if (nxt >= m_len) begin
          m_last = bus.core_result;
          nd = 1;
          m_pc = 0;
          if (!keep) m_run = 0;
        end else begin
          m_pc = nxt;
        end
      end else if (bus.clear) begin
        m_len = 0;
        m_have_low = 0;
      end else if (bus.start && !m_have_low) begin
        if (m_len > 0) begin
          m_run = 1;
          m_pc = 0;
        end else begin
          nd = 1;
        end
      end else if (bus.load_valid && m_len < DEPTH) begin
        if (!m_have_low) begin
          m_low = bus.load_data;
          m_have_low = 1;
        end else begin
          m_mem[m_len] = {bus.load_data, m_low};
          m_len++;
          m_have_low = 0;
        end
      end
      m_done = nd;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] d;
    logic [7:0] fill [$];
    logic [15:0] last_fill;

    bus.load_valid  = 1'b0;
    bus.load_data   = 8'h00;
    bus.start       = 1'b0;
    bus.clear       = 1'b0;
    bus.core_result = 8'h00;

    // Reset
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_instr_out",   32'(bus.instr_out),   32'h0003);
    checkOutput("rst_load_ready",  32'(bus.load_ready),  32'd1);
    checkOutput("rst_busy",        32'(bus.busy),        32'd0);
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_last_result", 32'(bus.last_result), 32'h00);
    checkOutput("rst_pc",          32'(bus.pc),          32'd0);

    // Two-instruction program, single pass
    loadBytes('{8'h05, 8'h20, 8'h03, 8'h00});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_load_ready", 32'(bus.load_ready), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_instr0", 32'(bus.instr_out), 32'h2005);
    checkOutput("t1_pc0",    32'(bus.pc),        32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_instr1", 32'(bus.instr_out), 32'h0003);
    checkOutput("t1_pc1",    32'(bus.pc),        32'd1);
    checkOutput("t1_done_early", 32'(bus.done),  32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_done",   32'(bus.done),      32'd1);
    checkOutput("t1_busy_end", 32'(bus.busy),    32'd0);

    // Fill the buffer, then offer a 17th byte
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) fill.push_back(8'(i));
    loadBytes(fill);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("fill_ready_low", 32'(bus.load_ready), 32'd0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
    checkOutput("fill_17th_ready", 32'(bus.load_ready), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    issued.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    runUntilDone(8'h00, "fill_run");
    checkOutput("fill_issue_count", 32'(issued.size()), 32'd8);
    last_fill = (issued.size() > 7) ? issued[7] : 16'hxxxx;
    checkOutput("fill_last_instr", 32'(last_fill), 32'h0F0E);

    // Compare/skip program: 0x6003, A=0x1235, B=0x4567
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    loadBytes('{8'h03, 8'h60, 8'h35, 8'h12, 8'h67, 8'h45});
    issued.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    runUntilDone(8'h00, "noskip_run");
    checkOutput("noskip_count", 32'(issued.size()), 32'd3);
    if (issued.size() == 3) begin
      checkOutput("noskip_i0", 32'(issued[0]), 32'h6003);
      checkOutput("noskip_i1", 32'(issued[1]), 32'h1235);
      checkOutput("noskip_i2", 32'(issued[2]), 32'h4567);
    end
    checkOutput("noskip_last", 32'(bus.last_result), 32'h00);
    issued.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h01);
    runUntilDone(8'h01, "skip_run");
    checkOutput("skip_count", 32'(issued.size()), 32'd2);
    if (issued.size() == 2) begin
      checkOutput("skip_i0", 32'(issued[0]), 32'h6003);
      checkOutput("skip_i1", 32'(issued[1]), 32'h4567);
    end
    checkOutput("skip_last", 32'(bus.last_result), 32'h01);

    // Start with only the low byte present is ignored
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 8'h13, 1'b0, 1'b0, 8'h80);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h80);
    checkOutput("half_busy", 32'(bus.busy), 32'd0);
    checkOutput("half_done", 32'(bus.done), 32'd0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 8'h80);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h80);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h80);
    checkOutput("half_run_busy",  32'(bus.busy),      32'd1);
    checkOutput("half_run_instr", 32'(bus.instr_out), 32'h0013);
    runUntilDone(8'h80, "half_run");
    checkOutput("half_last", 32'(bus.last_result), 32'h80);

    // Reset in the middle of RUN
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    loadBytes('{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("mrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    checkOutput("mrst_busy",        32'(bus.busy),        32'd0);
    checkOutput("mrst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("mrst_instr_out",   32'(bus.instr_out),   32'h0003);
    checkOutput("mrst_last_result", 32'(bus.last_result), 32'h00);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("mrst_len0_done", 32'(bus.done), 32'd1);
    checkOutput("mrst_len0_busy", 32'(bus.busy), 32'd0);

`ifdef RISCV_MINI_SEQ_LOOP_EN
    // Looping RUN: stop low for five cycles, then high
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    loadBytes('{8'h05, 8'h20, 8'h03, 8'h00});
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    pc_log.delete();
    done_seen = 0;
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("loop_busy_end", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("loop_pc_count", 32'(pc_log.size()), 32'd6);
    if (pc_log.size() == 6) begin
      for (int i = 0; i < 6; i++) checkOutput("loop_pc_seq", 32'(pc_log[i]), 32'(i % 2));
    end
    checkOutput("loop_done_count", 32'(done_seen), 32'd3);
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 4))
        0:       d = 8'h03;
        1:       d = 8'h63;
        2:       d = 8'h60;
        3:       d = 8'h7F;
        default: d = 8'($urandom);
      endcase
      rst_n = ($urandom_range(0, 399) != 0);
      applyStimulus($urandom_range(0, 9) < 7, d,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 49) == 0,
                    8'($urandom), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
